// File: rtl/simon_decrypt_control.sv
// Simon 32/64 decryption controller.
// Accepts a ciphertext and key, expands the 32 round keys one per clock,
// then runs the 32 inverse rounds one per clock and holds the plaintext
// until the host acknowledges it with readData.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for newData; plain holds the last result
// KEY    | expanding round keys k4..k31, one per edge (28 edges)
// DEC    | inverse rounds using k31..k0, one per edge (32 edges)
// DONE   | result valid, doneData high until readData is sampled
//
// Only N=16, M=4, T=32, C=5 (Simon 32/64) is supported.
module simon_decrypt_control #(
  parameter int N = 16,
  parameter int M = 4,
  parameter int T = 32,
  parameter int C = 5
) (
  input  logic                  clk,
  input  logic                  nR,
  input  logic                  newData,
  input  logic                  readData,
  input  logic [2*N-1:0]        cipher,
  input  logic [M-1:0][N-1:0]   key,
  output logic                  doneKey,
  output logic                  doneData,
  output logic [2*N-1:0]        plain
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEY  = 2'd1,
    S_DEC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // z0 with its first bit in the MSB; bit for step i sits at index 61-i.
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  localparam logic [C-1:0] KEY_LAST  = C'(T - M - 1);
  localparam logic [C-1:0] DEC_FIRST = C'(T - 1);
  localparam logic [N-1:0] KEY_CONST = {{(N-2){1'b1}}, 2'b00};

  state_t         r_state;
  state_t         w_next_state;
  logic [C-1:0]   r_cnt;
  logic [N-1:0]   r_rk [T];
  logic [N-1:0]   r_x;
  logic [N-1:0]   r_y;
  logic           r_done_key;
  logic           r_done_data;
  logic [2*N-1:0] r_plain;

  logic           w_accept;
  logic           w_key_step;
  logic           w_key_last;
  logic           w_dec_step;
  logic           w_dec_last;
  logic           w_release;

  logic [C-1:0]   w_idx1;
  logic [C-1:0]   w_idx3;
  logic [C-1:0]   w_idx4;
  logic [5:0]     w_zidx;
  logic           w_z;
  logic [N-1:0]   w_t;
  logic [N-1:0]   w_newk;
  logic [N-1:0]   w_f;
  logic [N-1:0]   w_ynew;

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return (v >> s) | (v << (N - s));
  endfunction

  // Round-key expansion: next key word from the four preceding ones.
  assign w_idx1 = r_cnt + C'(1);
  assign w_idx3 = r_cnt + C'(3);
  assign w_idx4 = r_cnt + C'(4);
  assign w_zidx = 6'd61 - 6'(r_cnt);
  assign w_z    = Z0[w_zidx];
  assign w_t    = ror(r_rk[w_idx3], 3) ^ r_rk[w_idx1];
  assign w_newk = KEY_CONST ^ {{(N-1){1'b0}}, w_z} ^ r_rk[r_cnt] ^ w_t ^ ror(w_t, 1);

  // Inverse round: x' = y, y' = x ^ f(y) ^ k.
  assign w_f    = (rol(r_y, 1) & rol(r_y, 8)) ^ rol(r_y, 2);
  assign w_ynew = r_x ^ w_f ^ r_rk[r_cnt];

  // State register.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; readData wins over newData in DONE by returning to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (newData)             w_next_state = S_KEY;
      S_KEY:   if (r_cnt == KEY_LAST)   w_next_state = S_DEC;
      S_DEC:   if (r_cnt == '0)         w_next_state = S_DONE;
      S_DONE:  if (readData)            w_next_state = S_IDLE;
      default:                          w_next_state = S_IDLE;
    endcase
  end

  // Per-state datapath strobes.
  always_comb begin
    w_accept   = 1'b0;
    w_key_step = 1'b0;
    w_key_last = 1'b0;
    w_dec_step = 1'b0;
    w_dec_last = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      S_IDLE: w_accept = newData;
      S_KEY: begin
        w_key_step = 1'b1;
        w_key_last = (r_cnt == KEY_LAST);
      end
      S_DEC: begin
        w_dec_step = 1'b1;
        w_dec_last = (r_cnt == '0);
      end
      S_DONE: w_release = readData;
      default: ;
    endcase
  end

  // Round-key file; contents are meaningless until doneKey, so no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < M; i++) r_rk[i] <= key[i];
    end else if (w_key_step) begin
      r_rk[w_idx4] <= w_newk;
    end
  end

  // Round counter: up through key expansion, down through decryption, parks at 0.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_key_last) begin
      r_cnt <= DEC_FIRST;
    end else if (w_key_step) begin
      r_cnt <= r_cnt + C'(1);
    end else if (w_dec_step && !w_dec_last) begin
      r_cnt <= r_cnt - C'(1);
    end
  end

  // Working words, result register and status flags.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      r_x         <= '0;
      r_y         <= '0;
      r_done_key  <= 1'b0;
      r_done_data <= 1'b0;
      r_plain     <= '0;
    end else begin
      if (w_accept) begin
        r_x        <= cipher[2*N-1:N];
        r_y        <= cipher[N-1:0];
        r_done_key <= 1'b0;
      end
      if (w_key_last) r_done_key <= 1'b1;
      if (w_dec_step) begin
        r_x <= r_y;
        r_y <= w_ynew;
      end
      if (w_dec_last) begin
        r_plain     <= {r_y, w_ynew};
        r_done_data <= 1'b1;
      end
      if (w_release) r_done_data <= 1'b0;
    end
  end

  assign doneKey  = r_done_key;
  assign doneData = r_done_data;
  assign plain    = r_plain;

endmodule

// File: doc/simon_decrypt_control.md
SIMON_DECRYPT_CONTROL -- requirements
Module: simon_decrypt_control

Interface
REQ-001 The block SHALL have parameter N, default 16: word size in bits.
REQ-002 The block SHALL have parameter M, default 4: key words.
REQ-003 The block SHALL have parameter T, default 32: rounds.
REQ-004 The block SHALL have parameter C, default 5: round-counter width.
REQ-005 Only N=16, M=4, T=32, C=5 (Simon 32/64) SHALL be supported.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port nR, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port newData, input, 1 bit: start request, level-sampled.
REQ-009 The block SHALL have port readData, input, 1 bit: host acknowledges the result.
REQ-010 The block SHALL have port cipher, input, 2N bits: ciphertext; [2N-1:N] = x, [N-1:0] = y.
REQ-011 The block SHALL have port key, input, [M-1:0][N-1:0]: key; key[0] = k0 (least significant word).
REQ-012 The block SHALL have port doneKey, output, 1 bit: round keys k0..k31 are expanded and valid.
REQ-013 The block SHALL have port doneData, output, 1 bit: plain holds a valid result.
REQ-014 The block SHALL have port plain, output, 2N bits: recovered plaintext, same x/y packing as cipher.

Function
REQ-015 The block SHALL implement FSM states IDLE, KEY, DEC and DONE.
REQ-016 In IDLE with newData=1 at a rising edge (accept edge E0), the block SHALL latch cipher and key, write key[0..3] into round-key file entries k0..k3, clear doneKey, enter KEY and set cnt=0.
REQ-017 In KEY, each edge SHALL write k[cnt+4] = 0xFFFC ^ z0[cnt] ^ k[cnt] ^ t ^ (t ROR 1), where t = (k[cnt+3] ROR 3) ^ k[cnt+1], and z0 = 62-bit Simon sequence 0, z0[0] is the first bit of 11111010001001010110000111001101111101000100101011000011100110.
REQ-018 KEY SHALL last 28 edges (E1..E28); at E28 the block SHALL set doneKey=1, enter DEC and set cnt=31.
REQ-019 In DEC, each edge SHALL apply the inverse round using k[cnt]: x_new = y, y_new = x ^ f(y) ^ k[cnt], where f(v) = ((v ROL 1) & (v ROL 8)) ^ (v ROL 2); cnt then decrements.
REQ-020 DEC SHALL last 32 edges (E29..E60); at E60 (cnt=0) the result SHALL load into plain, doneData SHALL be set to 1, and the FSM SHALL enter DONE; total latency is 60 edges after E0.
REQ-021 plain SHALL change only at DONE entry and at reset; it SHALL otherwise hold its last result.
REQ-022 In DONE, doneData SHALL stay 1 until readData=1 is sampled; on that edge doneData SHALL clear and the FSM SHALL return to IDLE.
REQ-023 newData in KEY, DEC or DONE SHALL be ignored; newData held across several cycles SHALL start exactly one operation.
REQ-024 readData outside DONE SHALL be ignored.
REQ-025 If newData=1 and readData=1 together in DONE, readData SHALL take priority: the FSM SHALL go to IDLE, and newData SHALL be acted on only if still high at a later IDLE edge.
REQ-026 doneKey SHALL stay 1 from E28 until the next accept edge or reset.
REQ-027 Changes to cipher or key after E0 SHALL not affect the operation in progress.
REQ-028 Rotations SHALL be modulo N; XORs SHALL be N-bit with no carries; cnt SHALL never wrap beyond 0..31.

Reset
REQ-029 nR=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, cnt=0, doneKey=0, doneData=0 and plain=0, from any state including mid-KEY or mid-DEC.
REQ-030 Round-key file contents after reset SHALL be don't-care; they SHALL never be observable before doneKey=1.
REQ-031 After nR rises, the block SHALL remain in IDLE until newData=1 is sampled.

Verification
REQ-032 Known-answer test: key=64'h1918111009080100, cipher=32'hC69BE9BB, newData high 2 cycles -> doneKey=1 28 edges after accept, doneData=1 60 edges after accept, plain=32'h65656877.
REQ-033 Handshake test: hold readData=0 for 20 cycles after doneData -> doneData and plain stay stable; assert readData for 2 cycles -> doneData=0 after the first edge, FSM in IDLE, plain still 32'h65656877.
REQ-034 Busy-ignore test: pulse newData at E10 and E40 with a different cipher -> result still 32'h65656877; a second vector applied after the read completes decrypts correctly.
REQ-035 Reset mid-DEC test: drop nR at E45 -> doneKey, doneData and plain go to 0 with no clock edge; after release with newData=0 for 100 cycles -> doneData stays 0.
REQ-036 Simultaneous-input test: newData and readData both 1 in DONE -> IDLE next edge; newData still 1 on the following edge -> a new accept.
REQ-037 Closed-loop test: 1000 random key/plaintext pairs encrypted by SIMON_control_INL and then decrypted by this block -> decrypted plain equals the original plaintext in every case.
